// File: rtl/dnn_pcie_host_driver_if.sv
// Slot link between the DNN host driver and the accelerator PCIe slot.
// master: host driver (tx beats out, rx grant out); slave: accelerator side.
interface dnn_pcie_host_driver_if #(
   parameter int PKT_DATA_W = 128
);
   logic                  tx_valid;
   logic [PKT_DATA_W-1:0] tx_data;
   logic                  tx_last;
   logic                  tx_full;
   logic                  rx_valid;
   logic [PKT_DATA_W-1:0] rx_data;
   logic                  rx_last;
   logic                  rx_grant;

   modport master (
      output tx_valid, tx_data, tx_last, rx_grant,
      input  tx_full, rx_valid, rx_data, rx_last
   );

   modport slave (
      input  tx_valid, tx_data, tx_last, rx_grant,
      output tx_full, rx_valid, rx_data, rx_last
   );
endinterface

// File: rtl/dnn_pcie_host_driver.sv
// Host driver: streams a programming image to the accelerator slot, then
// checks the result stream and reports run latency and error flags.
// Ports: clk, reset (sync, active-high); cfg_we/cfg_idx/cfg_data image load;
// go start; busy, done pulse, latency, err[3:0]; slot = slot link (master).
// Optional: `DNN_HOST_TIMEOUT_EN adds a WAIT_RESP watchdog (TIMEOUT_CYCLES).
module dnn_pcie_host_driver #(
   parameter int NUM_PROG_PKTS  = 4,
   parameter int NUM_RESP_PKTS  = 5,
   parameter int PKT_DATA_W     = 128,
   parameter int TIMEOUT_CYCLES = 2**20,
   localparam int IDX_W =
      (NUM_PROG_PKTS > 1) ? $clog2(NUM_PROG_PKTS) : 1,
   localparam int CNT_W =
      (NUM_RESP_PKTS > 1) ? $clog2(NUM_RESP_PKTS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [PKT_DATA_W-1:0] cfg_data,
   input  logic                  go,
   output logic                  busy,
   output logic                  done,
   output logic [63:0]           latency,
   output logic [3:0]            err,
   dnn_pcie_host_driver_if.master slot
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_RESP,
      DONE
   } state_t;

   state_t state, state_n;

   logic [PKT_DATA_W-1:0] cfg [NUM_PROG_PKTS];
   // Image snapshot taken at go, so a same-cycle cfg write
   // only affects later runs.
   logic [PKT_DATA_W-1:0] img [NUM_PROG_PKTS];

   logic [IDX_W-1:0] tx_idx;
   logic [CNT_W-1:0] rx_cnt;
   logic [63:0]      start_q;

   logic        tx_fire;
   logic        rx_acc;
   logic        last_tx;
   logic        last_rx;
   logic        to_hit;
   logic [63:0] rx_start;
   logic [63:0] rx_end;

   assign last_tx  = (tx_idx == IDX_W'(NUM_PROG_PKTS - 1));
   assign last_rx  = (rx_cnt == CNT_W'(NUM_RESP_PKTS - 1));
   assign rx_start = slot.rx_data[63:0];
   assign rx_end   = slot.rx_data[127:64];

`ifdef DNN_HOST_TIMEOUT_EN
   logic [31:0] wd;

   assign to_hit = (state == WAIT_RESP) && !slot.rx_valid &&
                   (wd == 32'(TIMEOUT_CYCLES - 1));
`else
   wire unused_timeout = TIMEOUT_CYCLES[0];

   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n       = state;
      busy          = 1'b0;
      done          = 1'b0;
      tx_fire       = 1'b0;
      rx_acc        = 1'b0;
      slot.tx_valid = 1'b0;
      slot.tx_data  = '0;
      slot.tx_last  = 1'b0;
      slot.rx_grant = 1'b0;
      unique case (state)
         IDLE: begin
            // Stray beats are drained so the slot never wedges.
            slot.rx_grant = slot.rx_valid;
            if (go) state_n = SEND;
         end
         SEND: begin
            busy          = 1'b1;
            tx_fire       = !slot.tx_full;
            slot.tx_valid = tx_fire;
            slot.tx_data  = img[tx_idx];
            slot.tx_last  = last_tx;
            if (tx_fire && last_tx) state_n = WAIT_RESP;
         end
         WAIT_RESP: begin
            busy          = 1'b1;
            slot.rx_grant = slot.rx_valid;
            rx_acc        = slot.rx_valid;
            if (rx_acc && (last_rx || slot.rx_last))
               state_n = DONE;
            else if (to_hit)
               state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg     <= '{default: '0};
         img     <= '{default: '0};
         tx_idx  <= '0;
         rx_cnt  <= '0;
         start_q <= '0;
         latency <= '0;
         err     <= '0;
`ifdef DNN_HOST_TIMEOUT_EN
         wd      <= '0;
`endif
      end else begin
         if (state == IDLE) begin
            if (cfg_we && (32'(cfg_idx) < NUM_PROG_PKTS))
               cfg[cfg_idx] <= cfg_data;
            if (go) begin
               img    <= cfg;
               tx_idx <= '0;
               rx_cnt <= '0;
               err    <= {slot.rx_valid, 3'b000};
`ifdef DNN_HOST_TIMEOUT_EN
               wd     <= '0;
`endif
            end else if (slot.rx_valid) begin
               err[3] <= 1'b1;
            end
         end

         if (tx_fire) tx_idx <= tx_idx + 1'b1;

         if (rx_acc) begin
            rx_cnt <= rx_cnt + 1'b1;
            if (rx_cnt == '0)
               start_q <= rx_start;
            else if (rx_start != start_q)
               err[2] <= 1'b1;
            unique case (1'b1)
               last_rx && slot.rx_last:
                  latency <= rx_end - rx_start;
               last_rx && !slot.rx_last:
                  err[1] <= 1'b1;
               !last_rx && slot.rx_last:
                  err[0] <= 1'b1;
               default: ;
            endcase
         end

`ifdef DNN_HOST_TIMEOUT_EN
         if (state == WAIT_RESP) begin
            if (rx_acc) wd <= '0;
            else        wd <= wd + 32'd1;
            if (to_hit) err[3] <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dnn_pcie_host_driver.sv
// Bench for dnn_pcie_host_driver: table of result-stream runs plus
// hand sequences for go/cfg overlap, tx_full stall, reset abort, watchdog.
module tb_dnn_pcie_host_driver;

   localparam int NP = 4;
`ifdef DNN_HOST_TIMEOUT_EN
   localparam int TO = 64;
`else
   localparam int TO = 2**20;
`endif

   typedef struct {
      logic [127:0] data;
      logic         last;
   } exp_t;

   typedef struct {
      logic [63:0] start;
      logic [63:0] end0;
      logic [63:0] step;
      int          n;
      int          last_at;
      int          bad;
      logic        stray;
      logic [3:0]  e_err;
      logic        chk_lat;
      logic [63:0] e_lat;
   } row_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_we;
   logic [1:0]   cfg_idx;
   logic [127:0] cfg_data;
   logic         go;
   logic         busy;
   logic         done;
   logic [63:0]  latency;
   logic [3:0]   err;

   dnn_pcie_host_driver_if #(.PKT_DATA_W(128)) slot ();

   dnn_pcie_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset   (reset),
      .cfg_we  (cfg_we),
      .cfg_idx (cfg_idx),
      .cfg_data(cfg_data),
      .go      (go),
      .busy    (busy),
      .done    (done),
      .latency (latency),
      .err     (err),
      .slot    (slot)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           tx_pops = 0;
   int           done_cnt = 0;
   exp_t         exp_q[$];
   logic [127:0] m_cfg [NP];
   row_t         rows [6];

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : tx_mon
      exp_t e;
      if (slot.tx_valid) begin
         if (exp_q.size() == 0) begin
            check("tx_extra", 128'd1, 128'd0);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", slot.tx_data, e.data);
            check("tx_last", 128'(slot.tx_last), 128'(e.last));
         end
         tx_pops++;
      end
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input int i, input logic [127:0] d);
      cfg_we   = 1'b1;
      cfg_idx  = 2'(i);
      cfg_data = d;
      tick();
      cfg_we   = 1'b0;
      m_cfg[i] = d;
   endtask

   task automatic push_image();
      for (int i = 0; i < NP; i++)
         exp_q.push_back('{m_cfg[i], (i == NP - 1)});
   endtask

   task automatic do_go();
      go = 1'b1;
      push_image();
      tick();
      go = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      check("tx_drain", 128'(exp_q.size()), 128'd0);
   endtask

   task automatic wait_pops(input int target);
      for (int i = 0; i < 40 && tx_pops < target; i++) begin
         @(negedge clk);
         #1;
      end
      check("tx_pops_reach", 128'(tx_pops >= target), 128'd1);
   endtask

   task automatic wait_resp_ready();
      tick();
      @(negedge clk);
      check("busy_wait", 128'(busy), 128'd1);
      tick();
   endtask

   task automatic send_rx(input logic [127:0] d, input logic l);
      slot.rx_valid = 1'b1;
      slot.rx_data  = d;
      slot.rx_last  = l;
      @(negedge clk);
      check("rx_grant", 128'(slot.rx_grant), 128'd1);
      tick();
      slot.rx_valid = 1'b0;
      slot.rx_last  = 1'b0;
   endtask

   task automatic finish_row(input int r);
      row_t        w;
      int          base;
      logic [63:0] s;
      w    = rows[r];
      base = done_cnt;
      for (int k = 0; k < w.n; k++) begin
         s = (k == w.bad) ? w.start + 64'd1 : w.start;
         send_rx({w.end0 + 64'(k) * w.step, s}, (k == w.last_at));
         if (k % 2 == 1 && k < w.n - 1) tick();
      end
      @(negedge clk);
      check("done_pulse", 128'(done), 128'd1);
      check("err", 128'(err), 128'(w.e_err));
      if (w.chk_lat) check("latency", 128'(latency), 128'(w.e_lat));
      tick();
      @(negedge clk);
      check("done_low", 128'(done), 128'd0);
      check("busy_idle", 128'(busy), 128'd0);
      tick();
      check("done_count", 128'(done_cnt - base), 128'd1);
      if (w.stray) begin
         send_rx({64'd999, w.start}, 1'b0);
         @(negedge clk);
         check("err_stray", 128'(err), 128'(w.e_err | 4'b1000));
         tick();
      end
   endtask

   task automatic run_row(input int r);
      do_go();
      drain();
      wait_resp_ready();
      finish_row(r);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1);
   end

   initial begin
      int           base;
      int           n;
      logic [127:0] nv;

      rows[0] = '{64'd100, 64'd200, 64'd7, 5, 4, -1, 1'b0,
                  4'b0000, 1'b1, 64'd128};
      rows[1] = '{64'd100, 64'd200, 64'd7, 3, 2, -1, 1'b0,
                  4'b0001, 1'b0, 64'd0};
      rows[2] = '{64'd50, 64'd60, 64'd1, 5, 4, 4, 1'b0,
                  4'b0100, 1'b1, 64'd13};
      rows[3] = '{64'd100, 64'd200, 64'd7, 5, -1, -1, 1'b1,
                  4'b0010, 1'b0, 64'd0};
      rows[4] = '{64'd1000, 64'd10, 64'd0, 5, 4, -1, 1'b0,
                  4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FC22};
      rows[5] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'd2, 5, 4, -1,
                  1'b0, 4'b0000, 1'b1, 64'h38};

      reset         = 1'b1;
      cfg_we        = 1'b0;
      cfg_idx       = '0;
      cfg_data      = '0;
      go            = 1'b0;
      slot.tx_full  = 1'b0;
      slot.rx_valid = 1'b0;
      slot.rx_data  = '0;
      slot.rx_last  = 1'b0;
      for (int i = 0; i < NP; i++) m_cfg[i] = '0;

      @(posedge clk);
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_tx_valid", 128'(slot.tx_valid), 128'd0);
      check("rst_tx_last", 128'(slot.tx_last), 128'd0);
      check("rst_rx_grant", 128'(slot.rx_grant), 128'd0);
      check("rst_tx_data", slot.tx_data, 128'd0);
      check("rst_latency", 128'(latency), 128'd0);
      check("rst_err", 128'(err), 128'd0);
      tick();
      reset = 1'b0;

      write_cfg(0, {16{8'h11}});
      write_cfg(1, {16{8'h22}});
      write_cfg(2, {16{8'h33}});
      write_cfg(3, {16{8'h44}});

      for (int r = 0; r < 6; r++) run_row(r);

      // go together with a cfg write: this run sees the old word 0
      nv       = {16{8'h5A}};
      cfg_we   = 1'b1;
      cfg_idx  = 2'd0;
      cfg_data = nv;
      go       = 1'b1;
      push_image();
      m_cfg[0] = nv;
      tick();
      go       = 1'b0;
      cfg_we   = 1'b0;
      drain();
      wait_resp_ready();
      finish_row(0);
      run_row(0);

      // tx_full stall for 3 cycles after two beats
      base = tx_pops;
      do_go();
      wait_pops(base + 2);
      slot.tx_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("tx_valid_full", 128'(slot.tx_valid), 128'd0);
      end
      #1;
      slot.tx_full = 1'b0;
      drain();
      wait_resp_ready();
      check("tx_count_full", 128'(tx_pops - base), 128'd4);
      finish_row(0);

      // reset mid-SEND after two beats
      base = tx_pops;
      do_go();
      wait_pops(base + 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_tx_valid", 128'(slot.tx_valid), 128'd0);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_count", 128'(tx_pops - base), 128'd2);
      tick();
      for (int i = 0; i < NP; i++) m_cfg[i] = '0;
      base = tx_pops;
      do_go();
      drain();
      check("resend_count", 128'(tx_pops - base), 128'd4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("reset2_busy", 128'(busy), 128'd0);
      tick();

`ifdef DNN_HOST_TIMEOUT_EN
      do_go();
      drain();
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      check("timeout_cycles", 128'(n), 128'd65);
      check("timeout_err", 128'(err), 128'(4'b1000));
      tick();
`else
      n = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
